// File: rtl/button_enable_gen.sv
// rtl/button_enable_gen.sv - debounced push-button to single-cycle enable pulse generator
// Optional auto-repeat while held is compiled in with `define AUTO_REPEAT_EN.

module button_enable_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic button_i,
    output logic enable_o,
    output logic pressed_o
);

    localparam int unsigned CNT_MAX = 32'h000F_FFFF;

    localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 2) && (DEBOUNCE_CYCLES <= CNT_MAX) &&
                               (REPEAT_DELAY    >= 2) && (REPEAT_DELAY    <= CNT_MAX) &&
                               (REPEAT_PERIOD   >= 2) && (REPEAT_PERIOD   <= CNT_MAX);

    // An out-of-range parameter set falls back to the shortest legal timing
    // instead of building a counter that could never reach its terminal value.
    localparam logic [19:0] DEB_LAST = PARAMS_OK ? 20'(DEBOUNCE_CYCLES - 1) : 20'd1;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_e;

    logic        sync1_q;
    logic        sync2_q;
    state_e      state_q;
    logic [19:0] cnt_q;
    logic        enable_q;
    logic        pressed_q;
    logic        btn_s;
    logic        cnt_done;

    assign btn_s    = sync2_q;
    assign cnt_done = (cnt_q == DEB_LAST);

`ifdef AUTO_REPEAT_EN
    localparam logic [19:0] RPT_DELAY_LAST  = PARAMS_OK ? 20'(REPEAT_DELAY - 1)  : 20'd1;
    localparam logic [19:0] RPT_PERIOD_LAST = PARAMS_OK ? 20'(REPEAT_PERIOD - 1) : 20'd1;

    logic [19:0] rpt_q;
    logic        rpt_first_q;
    logic        rpt_done;

    // The first repeat waits the long delay; later ones use the period.
    assign rpt_done = (rpt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST));
`endif

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= 20'd0;
            enable_q    <= 1'b0;
            pressed_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_q       <= 20'd0;
            rpt_first_q <= 1'b1;
`endif
        end else begin
            sync1_q  <= button_i;
            sync2_q  <= sync1_q;
            enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= 20'd0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q <= IDLE;
                    end else if (cnt_done) begin
                        state_q     <= HELD;
                        enable_q    <= 1'b1;
                        pressed_q   <= 1'b1;
`ifdef AUTO_REPEAT_EN
                        rpt_q       <= 20'd0;
                        rpt_first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= 20'd0;
`ifdef AUTO_REPEAT_EN
                    end else if (rpt_done) begin
                        enable_q    <= 1'b1;
                        rpt_q       <= 20'd0;
                        rpt_first_q <= 1'b0;
                    end else begin
                        rpt_q <= rpt_q + 20'd1;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    // Repeat counter is left untouched here so a release bounce resumes it.
                    if (btn_s) begin
                        state_q <= HELD;
                    end else if (cnt_done) begin
                        state_q     <= IDLE;
                        pressed_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
                        rpt_q       <= 20'd0;
                        rpt_first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign enable_o  = enable_q;
    assign pressed_o = pressed_q;

endmodule

// File: doc/button_enable_gen.md
BUTTON_ENABLE_GEN -- requirements
Module: button_enable_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronized samples required to accept a level change; legal range 2..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 64, number of HELD cycles before the first auto-repeat pulse; legal range 2..2^20-1; used only when AUTO_REPEAT_EN is defined.
REQ-003 Parameter REPEAT_PERIOD, default 16, number of cycles between subsequent auto-repeat pulses; legal range 2..2^20-1; used only when AUTO_REPEAT_EN is defined.
REQ-004 clock_i  input  1  sole clock; all flops rising-edge.
REQ-005 reset_i  input  1  reset, synchronous, active-high.
REQ-006 button_i  input  1  raw push-button, active-high, asynchronous to clock_i, may bounce.
REQ-007 enable_o  output  1  single-cycle registered pulse per accepted press; drives the downstream counter enable_i.
REQ-008 pressed_o  output  1  registered debounced button level.

Function
REQ-009 button_i SHALL pass through a 2-flop synchronizer; the second flop output is btn_s; no other logic SHALL sample button_i.
REQ-010 FSM states SHALL be IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus one 20-bit debounce counter cnt.
REQ-011 IDLE: btn_s=1 SHALL go to PRESS_WAIT with cnt=0; otherwise remain.
REQ-012 PRESS_WAIT: btn_s=0 SHALL return to IDLE with no pulse; btn_s=1 with cnt=DEBOUNCE_CYCLES-1 SHALL go to HELD and set enable_o=1 for the next cycle; otherwise cnt increments.
REQ-013 HELD: btn_s=0 SHALL go to RELEASE_WAIT with cnt=0; otherwise remain.
REQ-014 RELEASE_WAIT: btn_s=1 SHALL return to HELD with no new pulse; btn_s=0 with cnt=DEBOUNCE_CYCLES-1 SHALL go to IDLE; otherwise cnt increments.
REQ-015 pressed_o SHALL be 1 exactly while state is HELD or RELEASE_WAIT, registered with the state.
REQ-016 Latency: button_i stable high from before edge 0 SHALL produce enable_o=1 during the cycle after edge DEBOUNCE_CYCLES+2, for exactly one cycle.
REQ-017 enable_o SHALL never be high in two consecutive cycles.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no pulse and no pressed_o change.
REQ-019 cnt SHALL never wrap; it is only compared and incremented below DEBOUNCE_CYCLES-1.

Reset
REQ-020 reset_i=1 at a rising edge SHALL clear the synchronizer flops, cnt and all repeat counters, set state to IDLE, and set enable_o=0 and pressed_o=0 for the next cycle.
REQ-021 reset_i SHALL take priority over every FSM transition in the same cycle.
REQ-022 Reset SHALL abort any operation in progress; a button held through the deassertion of reset SHALL be debounced as a new press and produce one pulse per REQ-016, timed from the first edge with reset_i=0.

Configuration
REQ-023 Macro AUTO_REPEAT_EN SHALL compile in auto-repeat; without the macro, exactly one pulse SHALL be issued per accepted press, and no repeat counter SHALL exist.
REQ-024 With AUTO_REPEAT_EN, HELD SHALL count cycles: first repeat pulse REPEAT_DELAY cycles after the initial pulse, then every REPEAT_PERIOD cycles while in HELD.
REQ-025 With AUTO_REPEAT_EN, entry to RELEASE_WAIT SHALL freeze the repeat counter; a return to HELD SHALL resume it; entry to IDLE SHALL clear it.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
REQ-026 Clean press: button_i rises before edge 0 and is held -> enable_o=1 only in the cycle after edge 6; pressed_o=1 from the same cycle.
REQ-027 Bounce: button_i high 3 cycles, low 1, high 3, low -> enable_o stays 0, pressed_o stays 0.
REQ-028 Release bounce: in HELD, button_i low 2 cycles then high -> pressed_o stays 1 and no second pulse; a stable low 4+ sync cycles -> pressed_o=0.
REQ-029 Reset mid-press: reset_i=1 for 1 cycle while in PRESS_WAIT with cnt=2, button held -> outputs 0 next cycle; a single pulse follows 7 edges after reset deasserts.
REQ-030 AUTO_REPEAT_EN defined, button held 30 cycles after the initial pulse -> pulses at +0, +8, +12, +16, +20, +24, +28; without the macro -> only the +0 pulse.
